// File: rtl/dcpu_writeback.sv
// dcpu_writeback: DCPU-16 result-commit stage.
// Accepts one ALU result per wb_valid/wb_ready handshake and routes it to the
// register file, SP, PC, O or data memory, or raises skip for IF* opcodes.
// Ports:
//   clk, rst                       rising-edge clock, synchronous active-high reset
//   wb_valid/wb_ready              input handshake (ready only in IDLE)
//   opcode, a_code, a_addr         basic opcode, raw destination code, resolved memory address
//   result, overflow               ALU result and overflow word
//   reg_we/reg_waddr/reg_wdata     register-file write (1-cycle strobe)
//   sp_*/pc_*/o_*                  special-register writes (1-cycle strobes)
//   mem_req/mem_addr/mem_wdata     memory write request, held until mem_ack
//   mem_ack                        memory accepted the write
//   skip                           pulse with wb_done when an IF* condition is false
//   wb_done                        pulse: commit complete
module dcpu_writeback #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [3:0]        opcode,
  input  logic [5:0]        a_code,
  input  logic [DATA_W-1:0] a_addr,
  input  logic [DATA_W-1:0] result,
  input  logic [DATA_W-1:0] overflow,
  output logic              reg_we,
  output logic [REG_AW-1:0] reg_waddr,
  output logic [DATA_W-1:0] reg_wdata,
  output logic              sp_we,
  output logic [DATA_W-1:0] sp_wdata,
  output logic              pc_we,
  output logic [DATA_W-1:0] pc_wdata,
  output logic              o_we,
  output logic [DATA_W-1:0] o_wdata,
  output logic              mem_req,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              skip,
  output logic              wb_done
);

  typedef enum logic [1:0] {IDLE, COMMIT, MEM_WR} state_t;

  state_t state, state_nx;

  // Captured transaction
  logic              do_reg, do_sp, do_pc, do_o, do_mem, is_if, res0;
  logic [REG_AW-1:0] waddr_q;
  logic [DATA_W-1:0] data_q, o_q, addr_q;

  // Destination / opcode decode of the incoming transaction
  logic accept;
  logic op_if, op_nop, op_wr, op_ovf;
  logic dst_reg, dst_sp, dst_pc, dst_o, dst_mem;

  assign accept  = wb_valid && (state == IDLE);
  assign op_if   = (opcode >= 4'hC);
  assign op_nop  = (opcode == 4'h0);
  assign op_wr   = !op_if && !op_nop;
  assign op_ovf  = (opcode >= 4'h2 && opcode <= 4'h5) || opcode == 4'h7 || opcode == 4'h8;

  assign dst_reg = (a_code <= 6'h07);
  assign dst_sp  = (a_code == 6'h1b);
  assign dst_pc  = (a_code == 6'h1c);
  assign dst_o   = (a_code == 6'h1d);
  assign dst_mem = (a_code >= 6'h08 && a_code <= 6'h1a) || a_code == 6'h1e;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      do_reg  <= 1'b0;
      do_sp   <= 1'b0;
      do_pc   <= 1'b0;
      do_o    <= 1'b0;
      do_mem  <= 1'b0;
      is_if   <= 1'b0;
      res0    <= 1'b0;
      waddr_q <= '0;
      data_q  <= '0;
      o_q     <= '0;
      addr_q  <= '0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (accept) begin
            do_reg  <= op_wr && dst_reg;
            do_sp   <= op_wr && dst_sp;
            do_pc   <= op_wr && dst_pc;
            // Destination O takes the result; otherwise overflow-producing ops write O.
            do_o    <= op_wr && (op_ovf || dst_o);
            do_mem  <= op_wr && dst_mem;
            is_if   <= op_if;
            res0    <= result[0];
            waddr_q <= a_code[REG_AW-1:0];
            data_q  <= result;
            o_q     <= dst_o ? result : overflow;
            addr_q  <= a_addr;
          end
        end
        // O strobe belongs to the first request cycle only. The COMMIT cycle
        // that follows the ack then carries only wb_done, since every other
        // flag is already clear for a memory destination.
        MEM_WR: begin
          do_o <= 1'b0;
          if (mem_ack) do_mem <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    wb_ready = 1'b0;
    reg_we   = 1'b0;
    sp_we    = 1'b0;
    pc_we    = 1'b0;
    o_we     = 1'b0;
    mem_req  = 1'b0;
    skip     = 1'b0;
    wb_done  = 1'b0;
    case (state)
      IDLE: begin
        wb_ready = 1'b1;
        if (accept) state_nx = (op_wr && dst_mem) ? MEM_WR : COMMIT;
      end
      COMMIT: begin
        reg_we   = do_reg;
        sp_we    = do_sp;
        pc_we    = do_pc;
        o_we     = do_o;
        skip     = is_if && !res0;
        wb_done  = 1'b1;
        state_nx = IDLE;
      end
      MEM_WR: begin
        mem_req = 1'b1;
        o_we    = do_o;
        if (mem_ack) state_nx = COMMIT;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign reg_waddr = waddr_q;
  assign reg_wdata = data_q;
  assign sp_wdata  = data_q;
  assign pc_wdata  = data_q;
  assign o_wdata   = o_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = data_q;

endmodule

// File: tb/tb_dcpu_writeback.sv
module tb_dcpu_writeback;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [3:0]  opcode;
  logic [5:0]  a_code;
  logic [15:0] a_addr, result, overflow;
  logic        reg_we;
  logic [2:0]  reg_waddr;
  logic [15:0] reg_wdata;
  logic        sp_we, pc_we, o_we;
  logic [15:0] sp_wdata, pc_wdata, o_wdata;
  logic        mem_req;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic        skip, wb_done;

  int n_cmp  = 0;
  int n_fail = 0;

  dcpu_writeback #(.DATA_W(16), .REG_AW(3)) dut (
    .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_ready(wb_ready),
    .opcode(opcode), .a_code(a_code), .a_addr(a_addr), .result(result), .overflow(overflow),
    .reg_we(reg_we), .reg_waddr(reg_waddr), .reg_wdata(reg_wdata),
    .sp_we(sp_we), .sp_wdata(sp_wdata), .pc_we(pc_we), .pc_wdata(pc_wdata),
    .o_we(o_we), .o_wdata(o_wdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .skip(skip), .wb_done(wb_done)
  );

  always #5 clk = ~clk;

  // Present one transaction and let it be accepted at the next rising edge;
  // returns 1 time unit after that edge.
  task automatic accept(input logic [3:0] op, input logic [5:0] ac,
                        input logic [15:0] addr, input logic [15:0] res, input logic [15:0] ovf);
    @(negedge clk);
    n_cmp++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL accept.wb_ready got %b want 1", wb_ready); end
    wb_valid = 1'b1; opcode = op; a_code = ac; a_addr = addr; result = res; overflow = ovf;
    @(posedge clk); #1;
    wb_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; wb_valid = 1'b0; mem_ack = 1'b0;
    opcode = '0; a_code = '0; a_addr = '0; result = '0; overflow = '0;
    step(); step();
    rst = 1'b0;
    n_cmp++; if (wb_ready !== 1'b1) begin n_fail++; $display("FAIL reset.wb_ready got %b want 1", wb_ready); end
    n_cmp++; if ({reg_we, sp_we, pc_we, o_we, mem_req, skip, wb_done} !== 7'b0) begin n_fail++;
      $display("FAIL reset.strobes got %b want 0000000", {reg_we, sp_we, pc_we, o_we, mem_req, skip, wb_done}); end
    n_cmp++; if ({reg_wdata, mem_addr, o_wdata, reg_waddr} !== 51'd0) begin n_fail++;
      $display("FAIL reset.data got %h/%h/%h/%h want 0", reg_wdata, mem_addr, o_wdata, reg_waddr); end
  endtask

  task automatic test_add_reg;
    accept(4'h2, 6'h03, 16'h0000, 16'h1234, 16'h0001);
    n_cmp++; if ({reg_we, reg_waddr, reg_wdata} !== {1'b1, 3'd3, 16'h1234}) begin n_fail++;
      $display("FAIL add.reg got we=%b a=%0d d=%h want we=1 a=3 d=1234", reg_we, reg_waddr, reg_wdata); end
    n_cmp++; if ({o_we, o_wdata} !== {1'b1, 16'h0001}) begin n_fail++;
      $display("FAIL add.o got we=%b d=%h want we=1 d=0001", o_we, o_wdata); end
    n_cmp++; if ({wb_done, skip, mem_req, wb_ready} !== 4'b1000) begin n_fail++;
      $display("FAIL add.ctl got done,skip,req,rdy=%b want 1000", {wb_done, skip, mem_req, wb_ready}); end
    step();
    n_cmp++; if ({reg_we, o_we, wb_done, wb_ready} !== 4'b0001) begin n_fail++;
      $display("FAIL add.idle got %b want 0001", {reg_we, o_we, wb_done, wb_ready}); end
  endtask

  task automatic test_mem_delayed;
    int req_cycles = 0;
    accept(4'h1, 6'h1e, 16'h8000, 16'hBEEF, 16'h7777);
    for (int i = 0; i < 3; i++) begin
      if (mem_req === 1'b1) req_cycles++;
      n_cmp++; if ({mem_addr, mem_wdata} !== {16'h8000, 16'hBEEF}) begin n_fail++;
        $display("FAIL memd.stable cyc%0d got %h/%h want 8000/beef", i, mem_addr, mem_wdata); end
      n_cmp++; if ({wb_done, o_we, reg_we, wb_ready} !== 4'b0000) begin n_fail++;
        $display("FAIL memd.wait cyc%0d got %b want 0000", i, {wb_done, o_we, reg_we, wb_ready}); end
      step();
    end
    if (mem_req === 1'b1) req_cycles++;
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    n_cmp++; if (req_cycles !== 4) begin n_fail++; $display("FAIL memd.req_cycles got %0d want 4", req_cycles); end
    n_cmp++; if ({mem_req, wb_done, o_we, skip} !== 4'b0100) begin n_fail++;
      $display("FAIL memd.done got req,done,owe,skip=%b want 0100", {mem_req, wb_done, o_we, skip}); end
    step();
    n_cmp++; if ({wb_ready, wb_done} !== 2'b10) begin n_fail++; $display("FAIL memd.idle got %b want 10", {wb_ready, wb_done}); end
  endtask

  task automatic test_mem_min_latency;
    // MUL to memory: O strobe on the first request cycle, ack immediately.
    accept(4'h4, 6'h08, 16'h0042, 16'h0007, 16'h0003);
    n_cmp++; if ({mem_req, o_we, o_wdata, mem_addr} !== {1'b1, 1'b1, 16'h0003, 16'h0042}) begin n_fail++;
      $display("FAIL memmin.first got req=%b owe=%b od=%h a=%h want 1 1 0003 0042", mem_req, o_we, o_wdata, mem_addr); end
    // Inputs presented while busy must be ignored.
    wb_valid = 1'b1; a_addr = 16'hDEAD; result = 16'hDEAD; mem_ack = 1'b1;
    step();
    wb_valid = 1'b0; mem_ack = 1'b0;
    n_cmp++; if ({mem_req, wb_done, o_we, reg_we} !== 4'b0100) begin n_fail++;
      $display("FAIL memmin.done got %b want 0100", {mem_req, wb_done, o_we, reg_we}); end
    n_cmp++; if ({mem_addr, mem_wdata} !== {16'h0042, 16'h0007}) begin n_fail++;
      $display("FAIL memmin.held got %h/%h want 0042/0007", mem_addr, mem_wdata); end
    step();
  endtask

  task automatic test_if;
    accept(4'hC, 6'h00, 16'h0000, 16'h0000, 16'h0000);
    n_cmp++; if ({skip, wb_done, reg_we, o_we, sp_we, pc_we, mem_req} !== 7'b1100000) begin n_fail++;
      $display("FAIL ife_false got %b want 1100000", {skip, wb_done, reg_we, o_we, sp_we, pc_we, mem_req}); end
    step();
    accept(4'hC, 6'h00, 16'h0000, 16'h0001, 16'h0000);
    n_cmp++; if ({skip, wb_done, reg_we, o_we} !== 4'b0100) begin n_fail++;
      $display("FAIL ife_true got %b want 0100", {skip, wb_done, reg_we, o_we}); end
    step();
    // IF* with a memory destination still commits in one cycle, no request.
    accept(4'hF, 6'h1e, 16'h1000, 16'h0000, 16'h0000);
    n_cmp++; if ({skip, wb_done, mem_req} !== 3'b110) begin n_fail++;
      $display("FAIL ifb_mem got %b want 110", {skip, wb_done, mem_req}); end
    step();
  endtask

  task automatic test_o_dest;
    accept(4'h3, 6'h1d, 16'h0000, 16'h5555, 16'hFFFF);
    n_cmp++; if ({o_we, o_wdata, reg_we, wb_done} !== {1'b1, 16'h5555, 1'b0, 1'b1}) begin n_fail++;
      $display("FAIL odst got owe=%b od=%h rwe=%b done=%b want 1 5555 0 1", o_we, o_wdata, reg_we, wb_done); end
    step();
    n_cmp++; if (o_we !== 1'b0) begin n_fail++; $display("FAIL odst.single got %b want 0", o_we); end
  endtask

  task automatic test_literal;
    logic [5:0] codes [2] = '{6'h1f, 6'h25};
    for (int i = 0; i < 2; i++) begin
      accept(4'h1, codes[i], 16'h1111, 16'h2222, 16'h0000);
      n_cmp++; if ({wb_done, reg_we, sp_we, pc_we, o_we, mem_req} !== 6'b100000) begin n_fail++;
        $display("FAIL literal %h got %b want 100000", codes[i], {wb_done, reg_we, sp_we, pc_we, o_we, mem_req}); end
      step();
    end
  endtask

  task automatic test_back_to_back;
    // SET SP, then SET PC held valid through the COMMIT cycle.
    accept(4'h1, 6'h1b, 16'h0000, 16'h0100, 16'h0000);
    wb_valid = 1'b1; a_code = 6'h1c; result = 16'h0200;
    n_cmp++; if ({sp_we, sp_wdata, pc_we, wb_done} !== {1'b1, 16'h0100, 1'b0, 1'b1}) begin n_fail++;
      $display("FAIL b2b.sp got we=%b d=%h pcwe=%b done=%b want 1 0100 0 1", sp_we, sp_wdata, pc_we, wb_done); end
    step();
    n_cmp++; if ({wb_ready, pc_we} !== 2'b10) begin n_fail++; $display("FAIL b2b.gap got %b want 10", {wb_ready, pc_we}); end
    step();
    wb_valid = 1'b0;
    n_cmp++; if ({pc_we, pc_wdata, sp_we, o_we} !== {1'b1, 16'h0200, 1'b0, 1'b0}) begin n_fail++;
      $display("FAIL b2b.pc got we=%b d=%h spwe=%b owe=%b want 1 0200 0 0", pc_we, pc_wdata, sp_we, o_we); end
    step();
    // Opcodes 0x6 and 0x0 leave O alone.
    accept(4'h6, 6'h05, 16'h0000, 16'h0004, 16'h9999);
    n_cmp++; if ({reg_we, reg_waddr, o_we} !== {1'b1, 3'd5, 1'b0}) begin n_fail++;
      $display("FAIL mod got rwe=%b a=%0d owe=%b want 1 5 0", reg_we, reg_waddr, o_we); end
    step();
    accept(4'h0, 6'h02, 16'h0000, 16'h0004, 16'h9999);
    n_cmp++; if ({reg_we, o_we, wb_done} !== 3'b001) begin n_fail++;
      $display("FAIL nop got %b want 001", {reg_we, o_we, wb_done}); end
    step();
  endtask

  task automatic test_reset_mid_mem;
    accept(4'h1, 6'h10, 16'h4000, 16'hCAFE, 16'h0000);
    step();
    n_cmp++; if (mem_req !== 1'b1) begin n_fail++; $display("FAIL rstmem.req got %b want 1", mem_req); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_cmp++; if ({mem_req, wb_done, wb_ready} !== 3'b001) begin n_fail++;
      $display("FAIL rstmem.abort got %b want 001", {mem_req, wb_done, wb_ready}); end
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    n_cmp++; if ({mem_req, wb_done, wb_ready} !== 3'b001) begin n_fail++;
      $display("FAIL rstmem.stray_ack got %b want 001", {mem_req, wb_done, wb_ready}); end
    accept(4'h1, 6'h00, 16'h0000, 16'h00AA, 16'h0000);
    n_cmp++; if ({reg_we, reg_waddr, reg_wdata, wb_done} !== {1'b1, 3'd0, 16'h00AA, 1'b1}) begin n_fail++;
      $display("FAIL rstmem.next got we=%b a=%0d d=%h done=%b want 1 0 00aa 1", reg_we, reg_waddr, reg_wdata, wb_done); end
    step();
  endtask

  initial begin
    test_reset();
    test_add_reg();
    test_mem_delayed();
    test_mem_min_latency();
    test_if();
    test_o_dest();
    test_literal();
    test_back_to_back();
    test_reset_mid_mem();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
